// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
// Match-level sequencer for the pong game. Gates the physics engine
// through phys_run and serve_load, keeps both scores, inserts a
// frame-counted serve delay after every point, detects the end of the
// match and handles the start and pause buttons.
//
// Ports:
//   pclk        system clock
//   reset       synchronous, active-high reset
//   frame_tick  one-cycle pulse per video frame
//   start_btn   level; rising edge starts a match (from IDLE or OVER)
//   pause_btn   level; rising edge toggles between PLAY and PAUSED
//   miss_left   one-cycle pulse; point to the right player
//   miss_right  one-cycle pulse; point to the left player
//   phys_run    physics may advance (combinational, state == PLAY)
//   serve_load  one-cycle pulse; physics reloads the ball to centre
//   serve_dir   initial ball x-direction, 0 = left, 1 = right
//   score_l     left player score
//   score_r     right player score
//   game_over   match finished
//   winner      0 = left won, 1 = right won; valid while game_over
//   state       current FSM state, for debug and overlay
module pong_match_ctrl #(
    parameter int SCORE_WIDTH = 4,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int DELAY_WIDTH = 8
) (
    input  logic                   pclk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   start_btn,
    input  logic                   pause_btn,
    input  logic                   miss_left,
    input  logic                   miss_right,
    output logic                   phys_run,
    output logic                   serve_load,
    output logic                   serve_dir,
    output logic [SCORE_WIDTH-1:0] score_l,
    output logic [SCORE_WIDTH-1:0] score_r,
    output logic                   game_over,
    output logic                   winner,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        POINT      = 3'd3,
        PAUSED     = 3'd4,
        OVER       = 3'd5
    } state_t;

    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_WIDTH-1:0] SCORE_ONE  = SCORE_WIDTH'(1);
    localparam logic [SCORE_WIDTH-1:0] WIN_VAL    = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [DELAY_WIDTH-1:0] DELAY_LOAD = DELAY_WIDTH'(SERVE_DELAY);
    localparam logic [DELAY_WIDTH-1:0] DELAY_ONE  = DELAY_WIDTH'(1);

    state_t                 state_q;
    logic [DELAY_WIDTH-1:0] delay_cnt;
    logic                   start_prev;
    logic                   pause_prev;
    logic                   start_edge;
    logic                   pause_edge;

    assign start_edge = start_btn & ~start_prev;
    assign pause_edge = pause_btn & ~pause_prev;
    assign phys_run   = (state_q == PLAY);
    assign state      = state_q;

    // Button histories reset to 1 so a button held through reset does not
    // look like a fresh press once reset drops.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q    <= IDLE;
            score_l    <= '0;
            score_r    <= '0;
            serve_load <= 1'b0;
            serve_dir  <= 1'b1;
            game_over  <= 1'b0;
            winner     <= 1'b0;
            delay_cnt  <= '0;
            start_prev <= 1'b1;
            pause_prev <= 1'b1;
        end else begin
            start_prev <= start_btn;
            pause_prev <= pause_btn;
            serve_load <= 1'b0;

            case (state_q)
                IDLE, OVER: begin
                    if (start_edge) begin
                        score_l    <= '0;
                        score_r    <= '0;
                        game_over  <= 1'b0;
                        serve_dir  <= 1'b1;
                        serve_load <= 1'b1;
                        delay_cnt  <= DELAY_LOAD;
                        state_q    <= SERVE_WAIT;
                    end
                end

                // A frame tick coinciding with the serve_load pulse is not
                // counted, so the serve always waits a full SERVE_DELAY frames
                // after the ball has been reloaded.
                SERVE_WAIT: begin
                    if (frame_tick && !serve_load) begin
                        if (delay_cnt == DELAY_ONE) begin
                            state_q <= PLAY;
                        end else begin
                            delay_cnt <= delay_cnt - DELAY_ONE;
                        end
                    end
                end

                // miss_left has priority over miss_right, and any miss has
                // priority over a pause press in the same cycle.
                PLAY: begin
                    if (miss_left) begin
                        if (score_r != SCORE_MAX) begin
                            score_r <= score_r + SCORE_ONE;
                        end
                        serve_dir <= 1'b0;
                        state_q   <= POINT;
                    end else if (miss_right) begin
                        if (score_l != SCORE_MAX) begin
                            score_l <= score_l + SCORE_ONE;
                        end
                        serve_dir <= 1'b1;
                        state_q   <= POINT;
                    end else if (pause_edge) begin
                        state_q <= PAUSED;
                    end
                end

                POINT: begin
                    if (score_l == WIN_VAL || score_r == WIN_VAL) begin
                        game_over <= 1'b1;
                        winner    <= (score_r == WIN_VAL);
                        state_q   <= OVER;
                    end else begin
                        serve_load <= 1'b1;
                        delay_cnt  <= DELAY_LOAD;
                        state_q    <= SERVE_WAIT;
                    end
                end

                PAUSED: begin
                    if (pause_edge) begin
                        state_q <= PLAY;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl
// Directed self-checking bench for pong_match_ctrl with default parameters
// (SCORE_WIDTH=4, WIN_SCORE=7, SERVE_DELAY=60). Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point, so every check sees
// the result of the edge just taken.
module tb_pong_match_ctrl;

    localparam logic [31:0] ST_IDLE   = 32'd0;
    localparam logic [31:0] ST_SERVE  = 32'd1;
    localparam logic [31:0] ST_PLAY   = 32'd2;
    localparam logic [31:0] ST_POINT  = 32'd3;
    localparam logic [31:0] ST_PAUSED = 32'd4;
    localparam logic [31:0] ST_OVER   = 32'd5;

    logic       pclk;
    logic       reset;
    logic       frame_tick;
    logic       start_btn;
    logic       pause_btn;
    logic       miss_left;
    logic       miss_right;
    logic       phys_run;
    logic       serve_load;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    int compared;
    int mismatched;

    pong_match_ctrl #(
        .SCORE_WIDTH(4),
        .WIN_SCORE  (7),
        .SERVE_DELAY(60),
        .DELAY_WIDTH(8)
    ) dut (
        .pclk      (pclk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .start_btn (start_btn),
        .pause_btn (pause_btn),
        .miss_left (miss_left),
        .miss_right(miss_right),
        .phys_run  (phys_run),
        .serve_load(serve_load),
        .serve_dir (serve_dir),
        .score_l   (score_l),
        .score_r   (score_r),
        .game_over (game_over),
        .winner    (winner),
        .state     (state)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the pulse inputs for one clock, then clear them.
    task automatic applyStimulus(input logic ft, input logic ml, input logic mr);
        frame_tick = ft;
        miss_left  = ml;
        miss_right = mr;
        @(posedge pclk);
        #1;
        frame_tick = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    // Feed frame ticks until PLAY is reached, bounded by a cycle budget.
    task automatic waitPlay(input string tag);
        for (int i = 0; i < 200 && state != 3'd2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        checkOutput(tag, 32'(state), ST_PLAY);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        pause_btn  = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst_state", 32'(state), ST_IDLE);
        checkOutput("rst_score_l", 32'(score_l), 32'd0);
        checkOutput("rst_score_r", 32'(score_r), 32'd0);
        checkOutput("rst_serve_load", 32'(serve_load), 32'd0);
        checkOutput("rst_serve_dir", 32'(serve_dir), 32'd1);
        checkOutput("rst_game_over", 32'(game_over), 32'd0);
        checkOutput("rst_winner", 32'(winner), 32'd0);
        checkOutput("rst_phys_run", 32'(phys_run), 32'd0);

        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_after_rst", 32'(state), ST_IDLE);

        // Start a match; the tick during the serve_load cycle must not count.
        start_btn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("start_state", 32'(state), ST_SERVE);
        checkOutput("start_serve_load", 32'(serve_load), 32'd1);
        checkOutput("start_serve_dir", 32'(serve_dir), 32'd1);
        start_btn = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("serve_load_one_cycle", 32'(serve_load), 32'd0);
        for (int i = 0; i < 59; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        checkOutput("after_59_ticks", 32'(state), ST_SERVE);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("miss_ignored_serve", 32'(score_r), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("after_60_ticks", 32'(state), ST_PLAY);
        checkOutput("play_phys_run", 32'(phys_run), 32'd1);
        checkOutput("play_score_l", 32'(score_l), 32'd0);

        // miss_left: point to right, serve toward left.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("ml_score_r", 32'(score_r), 32'd1);
        checkOutput("ml_state", 32'(state), ST_POINT);
        checkOutput("ml_phys_run", 32'(phys_run), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ml_serve_load", 32'(serve_load), 32'd1);
        checkOutput("ml_serve_dir", 32'(serve_dir), 32'd0);
        checkOutput("ml_serve_state", 32'(state), ST_SERVE);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ml_serve_load_drop", 32'(serve_load), 32'd0);
        waitPlay("ml_back_to_play");

        // Both misses together: only the right player scores.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("both_score_r", 32'(score_r), 32'd2);
        checkOutput("both_score_l", 32'(score_l), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("both_serve_dir", 32'(serve_dir), 32'd0);
        waitPlay("both_back_to_play");

        // Pause press together with miss_right: the point wins.
        pause_btn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pmr_state", 32'(state), ST_POINT);
        checkOutput("pmr_score_l", 32'(score_l), 32'd1);
        pause_btn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pmr_serve_dir", 32'(serve_dir), 32'd1);
        checkOutput("pmr_serve_state", 32'(state), ST_SERVE);
        waitPlay("pmr_back_to_play");

        // Pause, try to disturb the frozen game, then resume.
        pause_btn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pause_state", 32'(state), ST_PAUSED);
        checkOutput("pause_phys_run", 32'(phys_run), 32'd0);
        pause_btn = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("paused_score_r", 32'(score_r), 32'd2);
        checkOutput("paused_score_l", 32'(score_l), 32'd1);
        checkOutput("paused_hold", 32'(state), ST_PAUSED);
        pause_btn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("resume_state", 32'(state), ST_PLAY);
        pause_btn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Left player runs up to 6, then takes the winning point.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            waitPlay("run_up_play");
        end
        checkOutput("score_l_six", 32'(score_l), 32'd6);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("win_score_l", 32'(score_l), 32'd7);
        checkOutput("win_point", 32'(state), ST_POINT);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("win_state", 32'(state), ST_OVER);
        checkOutput("win_game_over", 32'(game_over), 32'd1);
        checkOutput("win_winner", 32'(winner), 32'd0);
        checkOutput("win_no_serve", 32'(serve_load), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        pause_btn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        pause_btn = 1'b0;
        checkOutput("over_score_l", 32'(score_l), 32'd7);
        checkOutput("over_score_r", 32'(score_r), 32'd2);
        checkOutput("over_hold", 32'(state), ST_OVER);

        // Restart from OVER clears the match.
        start_btn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("restart_state", 32'(state), ST_SERVE);
        checkOutput("restart_score_l", 32'(score_l), 32'd0);
        checkOutput("restart_game_over", 32'(game_over), 32'd0);
        checkOutput("restart_serve_load", 32'(serve_load), 32'd1);
        start_btn = 1'b0;
        waitPlay("restart_play");

        // Right player wins 7-0.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            waitPlay("right_run_play");
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rwin_state", 32'(state), ST_OVER);
        checkOutput("rwin_score_r", 32'(score_r), 32'd7);
        checkOutput("rwin_winner", 32'(winner), 32'd1);

        // Reset in the middle of a serve wait.
        start_btn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pre_rst_state", 32'(state), ST_SERVE);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("mid_rst_state", 32'(state), ST_IDLE);
        checkOutput("mid_rst_score_r", 32'(score_r), 32'd0);
        checkOutput("mid_rst_serve_load", 32'(serve_load), 32'd0);

        // start_btn held through reset release must not start a match.
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("held_start_idle", 32'(state), ST_IDLE);
        start_btn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        start_btn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("fresh_start", 32'(state), ST_SERVE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match-level sequencer for the pong game.
- Gates the ball/paddle physics engine through run and serve-reload controls.
- Consumes miss events from the physics collision logic, keeps both scores, and inserts a frame-counted serve delay after every point.
- Detects match end and handles start and pause buttons.

Parameters:
- SCORE_WIDTH, 4, width of each score counter.
- WIN_SCORE, 7, points that end the match; must satisfy 1 <= WIN_SCORE <= 2^SCORE_WIDTH-1.
- SERVE_DELAY, 60, frame ticks spent in SERVE_WAIT before play resumes; must be >= 1.
- DELAY_WIDTH, 8, width of the serve delay counter; must hold SERVE_DELAY.

Ports:
- pclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame, from the VGA timing block.
- start_btn  in  1  level; the rising edge starts a match.
- pause_btn  in  1  level; the rising edge toggles pause.
- miss_left  in  1  one-cycle pulse: ball passed the left paddle (point to right player).
- miss_right  in  1  one-cycle pulse: ball passed the right paddle (point to left player).
- phys_run  out  1  physics engine may advance ball and paddles.
- serve_load  out  1  one-cycle pulse: physics reloads ball to centre.
- serve_dir  out  1  initial ball x-direction: 0 = toward left, 1 = toward right.
- score_l  out  SCORE_WIDTH  left player score.
- score_r  out  SCORE_WIDTH  right player score.
- game_over  out  1  match finished.
- winner  out  1  0 = left won, 1 = right won; valid while game_over=1.
- state  out  3  current FSM state, for debug and overlay.

Behaviour:
- Reset, synchronous, overrides all other activity including mid-match:
  - state=IDLE; score_l=score_r=0; serve_load=0; serve_dir=1; game_over=0; winner=0; delay counter=0.
  - Button edge-detect history registers reset to 1, so a button held through reset produces no edge.
- Edge detect: start_edge = start_btn & ~start_prev. pause_edge is formed the same way. Both histories update every cycle.
- State encoding: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, PAUSED=4, OVER=5. Encodings 6-7 return to IDLE on the next cycle.
- phys_run is combinational: 1 iff state==PLAY. All other outputs are registered.
- IDLE or OVER with start_edge:
  - score_l=score_r=0, game_over=0, serve_dir=1.
  - serve_load=1 for one cycle, delay counter=SERVE_DELAY, go to SERVE_WAIT.
  - Pause edges and misses are ignored in IDLE and OVER.
- SERVE_WAIT:
  - On frame_tick: if counter==1, go to PLAY; else decrement the counter.
  - A frame_tick in the same cycle serve_load is asserted is not counted.
  - Misses and pause edges are ignored.
- PLAY:
  - miss_left: score_r+1, serve_dir=0, go to POINT.
  - miss_right: score_l+1, serve_dir=1, go to POINT.
  - Both misses in the same cycle: miss_left wins; miss_right is dropped.
  - A miss beats a simultaneous pause_edge.
  - pause_edge with no miss: go to PAUSED.
  - Scores saturate at 2^SCORE_WIDTH-1 and never wrap.
- POINT lasts exactly one cycle:
  - If score_l==WIN_SCORE or score_r==WIN_SCORE: go to OVER, game_over=1, winner=(score_r==WIN_SCORE).
  - Otherwise: serve_load=1, counter=SERVE_DELAY, go to SERVE_WAIT.
- PAUSED:
  - pause_edge: return to PLAY.
  - Misses are ignored, since the physics engine is frozen.
  - start_edge is ignored.
- Latency: a miss pulse in cycle t gives updated score and state=POINT in t+1, then serve_load=1 with state=SERVE_WAIT (or game_over=1 with state=OVER) in t+2.
- serve_load is never high for more than one consecutive cycle.

Test Plan:
- Reset, then start_btn rising edge -> serve_load=1 for one cycle, state=1; after exactly SERVE_DELAY=60 frame_ticks, state=2 and phys_run=1; scores stay 0.
- In PLAY, pulse miss_left -> next cycle score_r=1 and state=3; following cycle serve_load=1, serve_dir=0, state=1.
- Drive score_l to 6 with WIN_SCORE=7, then pulse miss_right -> score_l=7, then game_over=1, winner=0, state=5; further misses leave scores unchanged; start edge clears scores and game_over.
- In PLAY, assert miss_left and miss_right in the same cycle -> only score_r increments; assert pause_edge together with miss_right -> POINT taken, no pause.
- pause_edge in PLAY -> state=4, phys_run=0; a miss and frame_ticks while paused change nothing; a second pause_edge -> state=2.
- Hold start_btn high through reset deassertion -> no match starts (state stays 0); assert reset mid-SERVE_WAIT -> next cycle state=0, scores 0, serve_load=0.
